// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin front end that serialises the cache ports'
// traffic onto the single slowmem instance. One transaction is in flight
// at a time. Completion, read data and timeout errors are routed back to
// the owning port as one-cycle pulses. Every output is a register.
module mem_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rnotw,
  input  logic [NREQ*16-1:0]   req_addr,
  input  logic [NREQ*16-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic [15:0]          rdata,
  output logic                 err,
  output logic                 busy,
  output logic                 mem_strobe,
  output logic                 mem_rnotw,
  output logic [15:0]          mem_addr,
  output logic [15:0]          mem_wdata,
  input  logic                 mem_mfc,
  input  logic [15:0]          mem_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PLAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // One-hot decode of a port index.
  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < NREQ; k++) oh[k] = (PW'(k) == i);
    return oh;
  endfunction

  // Extract port i's 16-bit lane from a packed per-port bus.
  function automatic logic [15:0] lane(input logic [NREQ*16-1:0] bus,
                                       input logic [PW-1:0]      i);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < NREQ; k++)
      if (PW'(k) == i) v = bus[16*k +: 16];
    return v;
  endfunction

  // First requester at or after the pointer, modulo NREQ.
  // Returns {found, index}; scanning from the far end lets the nearest win.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [PW-1:0]   p);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      for (int j = 0; j < NREQ; j++)
        if (j == idx && r[j]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  // Pointer advance with wrap from the last port back to port 0.
  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
    return (w == PLAST) ? '0 : w + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             strobe_q, strobe_d;
  logic             rnotw_q, rnotw_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [PW:0]      pick;
  logic [PW-1:0]    win;

  // Next-state and next-output logic; pulses default low every cycle,
  // slowmem operands hold their last values between strobes.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    ack_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
    strobe_d = 1'b0;
    rnotw_d  = rnotw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    pick     = rr_pick(req, ptr_q);
    win      = pick[PW-1:0];

    case (state_q)
      IDLE: begin
        // req is only looked at here, so a port dropping req early is harmless
        // and a done cycle can never coincide with a new ack.
        if (pick[PW]) begin
          ack_d    = onehot(win);
          owner_d  = win;
          strobe_d = 1'b1;
          rnotw_d  = |(req_rnotw & onehot(win));
          addr_d   = lane(req_addr, win);
          wdata_d  = lane(req_wdata, win);
          ptr_d    = ptr_after(win);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (rnotw_q) begin
          timer_d = '0;
          state_d = WAIT;
        end else begin
          done_d  = onehot(owner_q);
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_mfc) begin
          rdata_d = mem_rdata;
          done_d  = onehot(owner_q);
          state_d = IDLE;
        end else if (timer_q == TLAST) begin
          rdata_d = '0;
          done_d  = onehot(owner_q);
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      timer_q  <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      rnotw_q  <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      rnotw_q  <= rnotw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign rdata      = rdata_q;
  assign mem_strobe = strobe_q;
  assign mem_rnotw  = rnotw_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: drives the cache ports, models slowmem with a
// four-cycle read delay, and compares completions against a scoreboard.
module tb_mem_arbiter;

  localparam int NREQ     = 3;
  localparam int TIMEOUT  = 16;
  localparam int MEMDELAY = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    req_rnotw = '1;
  logic [NREQ*16-1:0] req_addr = '0;
  logic [NREQ*16-1:0] req_wdata = '0;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    done;
  logic [15:0]        rdata;
  logic               err;
  logic               busy;
  logic               mem_strobe;
  logic               mem_rnotw;
  logic [15:0]        mem_addr;
  logic [15:0]        mem_wdata;
  logic               mem_mfc = 1'b0;
  logic [15:0]        mem_rdata = '0;

  mem_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_rnotw(req_rnotw), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .done(done), .rdata(rdata), .err(err), .busy(busy),
    .mem_strobe(mem_strobe), .mem_rnotw(mem_rnotw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mfc(mem_mfc), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [15:0] rdata;
    logic        err;
    logic        rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Contents of never-written slowmem locations.
  function automatic logic [15:0] dflt(input logic [15:0] a);
    if (a == 16'h0010) return 16'h1234;
    return a ^ 16'hA5A5;
  endfunction

  // slowmem model: every strobe restarts it; reads complete MEMDELAY edges
  // after the strobe is sampled and mfc then stays high until the next strobe.
  logic [15:0] wmem [0:65535];
  bit          wvalid [0:65535];
  logic        mute_mfc = 1'b0;
  logic [15:0] m_raddr = '0;
  int          m_cnt = 0;
  logic        m_pend = 1'b0;

  always @(posedge clk) begin
    if (mem_strobe) begin
      if (!mem_rnotw) begin
        wmem[mem_addr]   <= mem_wdata;
        wvalid[mem_addr] <= 1'b1;
      end
      mem_mfc <= 1'b0;
      m_raddr <= mem_addr;
      m_cnt   <= MEMDELAY;
      m_pend  <= mem_rnotw & ~mute_mfc;
    end else if (m_pend) begin
      if (m_cnt == 1) begin
        mem_mfc   <= 1'b1;
        mem_rdata <= wvalid[m_raddr] ? wmem[m_raddr] : dflt(m_raddr);
        m_pend    <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Strobe watcher: records back-to-back strobes and counts strobe pulses.
  logic prev_strobe = 1'b0;
  logic strobe_violation = 1'b0;
  int   strobe_count = 0;

  always @(negedge clk) begin
    if (mem_strobe === 1'b1) begin
      strobe_count <= strobe_count + 1;
      if (prev_strobe) strobe_violation <= 1'b1;
    end
    prev_strobe <= (mem_strobe === 1'b1);
  end

  // Drive one request on port p and observe ack, strobe and done timing
  // (cycle 0 is the first edge after req rises).
  task automatic run_txn(input int p, input logic rw, input logic [15:0] a,
                         input logic [15:0] wd,
                         output int ack_cyc, output logic [NREQ-1:0] ack_vec,
                         output int done_cyc, output logic [NREQ-1:0] done_vec,
                         output logic [15:0] rd, output logic er,
                         output int strobe_n, output int strobe_cyc);
    ack_cyc = -1; ack_vec = '0; done_cyc = -1; done_vec = '0;
    rd = '0; er = 1'b0; strobe_n = 0; strobe_cyc = -1;
    req_rnotw[p]         = rw;
    req_addr[16*p +: 16]  = a;
    req_wdata[16*p +: 16] = wd;
    req[p]               = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (mem_strobe) begin strobe_n++; strobe_cyc = t; end
      if (ack != 0 && ack_cyc < 0) begin
        ack_cyc = t; ack_vec = ack; req[p] = 1'b0;
      end
      if (done != 0) begin
        done_cyc = t; done_vec = done; rd = rdata; er = err;
        break;
      end
    end
    req[p] = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    req = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL rst_ack: got %b want 000", ack); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL rst_done: got %b want 000", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (mem_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b want 0", mem_strobe); end
    checks++; if (mem_rnotw !== 1'b1) begin errors++; $display("FAIL rst_rnotw: got %b want 1", mem_rnotw); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_wdata: got %h want 0000", mem_wdata); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    int ac, dc, sn, sc; logic [NREQ-1:0] av, dv; logic [15:0] rd; logic er; exp_t e;
    exp_q.push_back('{port: 0, rdata: 16'h1234, err: 1'b0, rd: 1'b1});
    run_txn(0, 1'b1, 16'h0010, 16'h0000, ac, av, dc, dv, rd, er, sn, sc);
    checks++; if (av !== 3'b001) begin errors++; $display("FAIL t1_ack: got %b want 001", av); end
    checks++; if (ac != 0) begin errors++; $display("FAIL t1_ack_cycle: got %0d want 0", ac); end
    checks++; if (sn != 1 || sc != 0) begin errors++; $display("FAIL t1_strobe: got %0d pulses at %0d want 1 at 0", sn, sc); end
    checks++; if (dc - ac != 6) begin errors++; $display("FAIL t1_latency: got %0d want 6", dc - ac); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL t1_addr_hold: got %h want 0010", mem_addr); end
    if (dv != 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (dv !== NREQ'(1 << e.port)) begin errors++; $display("FAIL t1_done: got %b want port %0d", dv, e.port); end
      checks++; if (rd !== e.rdata) begin errors++; $display("FAIL t1_rdata: got %h want %h", rd, e.rdata); end
      checks++; if (er !== e.err) begin errors++; $display("FAIL t1_err: got %b want %b", er, e.err); end
    end else begin
      checks++; errors++; $display("FAIL t1_no_done: got none want port 0");
      exp_q.delete();
    end
  endtask

  task automatic test_single_write;
    int ac, dc, sn, sc; logic [NREQ-1:0] av, dv; logic [15:0] rd; logic er; exp_t e;
    exp_q.push_back('{port: 2, rdata: 16'h0000, err: 1'b0, rd: 1'b0});
    run_txn(2, 1'b0, 16'h8001, 16'hBEEF, ac, av, dc, dv, rd, er, sn, sc);
    checks++; if (av !== 3'b100) begin errors++; $display("FAIL t2_ack: got %b want 100", av); end
    checks++; if (dc - ac != 1) begin errors++; $display("FAIL t2_latency: got %0d want 1", dc - ac); end
    checks++; if (!(wvalid[16'h8001] && wmem[16'h8001] === 16'hBEEF)) begin
      errors++; $display("FAIL t2_mem: got %h want beef", wmem[16'h8001]);
    end
    if (dv != 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (dv !== NREQ'(1 << e.port)) begin errors++; $display("FAIL t2_done: got %b want port %0d", dv, e.port); end
      checks++; if (er !== e.err) begin errors++; $display("FAIL t2_err: got %b want %b", er, e.err); end
    end else begin
      checks++; errors++; $display("FAIL t2_no_done: got none want port 2");
      exp_q.delete();
    end
    exp_q.push_back('{port: 2, rdata: 16'hBEEF, err: 1'b0, rd: 1'b1});
    run_txn(2, 1'b1, 16'h8001, 16'h0000, ac, av, dc, dv, rd, er, sn, sc);
    checks++; if (dc - ac != 6) begin errors++; $display("FAIL t2_rd_latency: got %0d want 6", dc - ac); end
    if (dv != 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (dv !== NREQ'(1 << e.port)) begin errors++; $display("FAIL t2_rd_done: got %b want port %0d", dv, e.port); end
      checks++; if (rd !== e.rdata) begin errors++; $display("FAIL t2_readback: got %h want %h", rd, e.rdata); end
    end else begin
      checks++; errors++; $display("FAIL t2_rd_no_done: got none want port 2");
      exp_q.delete();
    end
  endtask

  task automatic test_contention;
    int acks, w, d; bit outstanding; exp_t e;
    do_reset();
    req_rnotw = 3'b011;
    req_addr  = {16'h0200, 16'h0101, 16'h0100};
    req_wdata = {16'h7000, 16'h0000, 16'h0000};
    acks = 0; outstanding = 0;
    req = 3'b111;
    for (int t = 0; t < 300 && (acks < 6 || outstanding); t++) begin
      @(posedge clk); #1;
      if (ack != 0) begin
        w = 0;
        for (int k = 0; k < NREQ; k++) if (ack[k]) w = k;
        checks++; if (outstanding) begin errors++; $display("FAIL t3_overlap: got ack %b before done want done first", ack); end
        checks++; if (!$onehot(ack)) begin errors++; $display("FAIL t3_onehot: got %b want one-hot", ack); end
        checks++; if (w != acks % NREQ) begin errors++; $display("FAIL t3_order: got port %0d want %0d", w, acks % NREQ); end
        exp_q.push_back('{port: w, rdata: (w == 2) ? 16'h0000 : dflt(16'h0100 + 16'(w)), err: 1'b0, rd: (w != 2)});
        req[w] = 1'b0;
        outstanding = 1;
        acks++;
        if (acks >= 6) req = '0;
      end
      if (done != 0) begin
        d = 0;
        for (int k = 0; k < NREQ; k++) if (done[k]) d = k;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++; if (done !== NREQ'(1 << e.port)) begin errors++; $display("FAIL t3_done: got %b want port %0d", done, e.port); end
          if (e.rd) begin
            checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL t3_rdata: got %h want %h", rdata, e.rdata); end
          end
        end else begin
          checks++; errors++; $display("FAIL t3_spurious_done: got %b want none", done);
        end
        outstanding = 0;
        if (acks < 6) req[d] = 1'b1;
      end
    end
    req = '0;
    checks++; if (acks != 6 || outstanding || exp_q.size() != 0) begin
      errors++; $display("FAIL t3_complete: got %0d acks, %0d pending want 6 acks, 0 pending", acks, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_timeout;
    int ac, dc, sn, sc; logic [NREQ-1:0] av, dv; logic [15:0] rd; logic er; exp_t e;
    mute_mfc = 1'b1;
    exp_q.push_back('{port: 1, rdata: 16'h0000, err: 1'b1, rd: 1'b1});
    run_txn(1, 1'b1, 16'h0300, 16'h0000, ac, av, dc, dv, rd, er, sn, sc);
    checks++; if (av !== 3'b010) begin errors++; $display("FAIL t4_ack: got %b want 010", av); end
    checks++; if (dc - ac != TIMEOUT + 1) begin errors++; $display("FAIL t4_latency: got %0d want %0d", dc - ac, TIMEOUT + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy: got %b want 0", busy); end
    if (dv != 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (dv !== NREQ'(1 << e.port)) begin errors++; $display("FAIL t4_done: got %b want port %0d", dv, e.port); end
      checks++; if (rd !== e.rdata) begin errors++; $display("FAIL t4_rdata: got %h want %h", rd, e.rdata); end
      checks++; if (er !== e.err) begin errors++; $display("FAIL t4_err: got %b want %b", er, e.err); end
    end else begin
      checks++; errors++; $display("FAIL t4_no_done: got none want port 1");
      exp_q.delete();
    end
    mute_mfc = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int ac, dc, sn, sc; logic [NREQ-1:0] av, dv; logic [15:0] rd; logic er; exp_t e;
    bit got_ack;
    got_ack = 0;
    req_rnotw[1] = 1'b1;
    req_addr[31:16] = 16'h0010;
    req[1] = 1'b1;
    for (int t = 0; t < 20 && !got_ack; t++) begin
      @(posedge clk); #1;
      if (ack[1]) got_ack = 1;
    end
    req[1] = 1'b0;
    checks++; if (!got_ack) begin errors++; $display("FAIL t5_ack: got none want ack[1]"); end
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b want 0", busy); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL t5_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_rnotw !== 1'b1 || mem_strobe !== 1'b0) begin
      errors++; $display("FAIL t5_mem_ctl: got rnotw %b strobe %b want 1 0", mem_rnotw, mem_strobe);
    end
    checks++; if (ack !== 3'b000 || done !== 3'b000 || err !== 1'b0 || rdata !== 16'h0000) begin
      errors++; $display("FAIL t5_outputs: got ack %b done %b err %b rdata %h want all zero", ack, done, err, rdata);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      checks++; if (done !== 3'b000 || err !== 1'b0 || ack !== 3'b000) begin
        errors++; $display("FAIL t5_stale: got done %b err %b ack %b want 000 0 000", done, err, ack);
      end
    end
    exp_q.push_back('{port: 0, rdata: 16'h1234, err: 1'b0, rd: 1'b1});
    run_txn(0, 1'b1, 16'h0010, 16'h0000, ac, av, dc, dv, rd, er, sn, sc);
    checks++; if (av !== 3'b001 || dc - ac != 6) begin
      errors++; $display("FAIL t5_next: got ack %b latency %0d want 001 6", av, dc - ac);
    end
    if (dv != 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (dv !== NREQ'(1 << e.port) || rd !== e.rdata || er !== e.err) begin
        errors++; $display("FAIL t5_next_done: got %b %h %b want port %0d %h %b", dv, rd, er, e.port, e.rdata, e.err);
      end
    end else begin
      checks++; errors++; $display("FAIL t5_next_no_done: got none want port 0");
      exp_q.delete();
    end
  endtask

  task automatic test_strobe;
    @(negedge clk);
    @(negedge clk);
    checks++; if (strobe_violation !== 1'b0) begin errors++; $display("FAIL t6_strobe_pair: got consecutive strobes want none"); end
    checks++; if (strobe_count != 12) begin errors++; $display("FAIL t6_strobe_count: got %0d want 12", strobe_count); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_timeout();
    test_reset_mid_read();
    test_strobe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
